// File: rtl/bitline_add_ctrl.sv
// Bit-serial add sequencer for a transposed SRAM array: per bit reads A row, B row, writes sum row.
// Optional macro BITLINE_ADD_CTRL_SUB_EN adds a sub input selecting A - B (two's complement via inverted B).
module bitline_add_ctrl #(
  parameter int WIDTH  = 8,
  parameter int COLS   = 16,
  parameter int ADDR_W = 6
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
`ifdef BITLINE_ADD_CTRL_SUB_EN
  input  logic              sub,
`endif
  input  logic [ADDR_W-1:0] a_base,
  input  logic [ADDR_W-1:0] b_base,
  input  logic [ADDR_W-1:0] r_base,
  output logic              busy,
  output logic              done,
  output logic [COLS-1:0]   carry_out,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd_en,
  input  logic [COLS-1:0]   mem_rdata,
  output logic              mem_wr_en,
  output logic [COLS-1:0]   mem_wdata
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(WIDTH - 1);

  // state | meaning
  // IDLE  | waiting for start, array port released
  // RD_A  | read strobe on A row of current bit
  // RD_B  | read strobe on B row, A data arrives and is captured
  // WR    | B data arrives, sum row written, carry updated
  // DONE  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, RD_A, RD_B, WR, DONE} state_t;

  state_t            state_q, state_d;
  logic [IDX_W-1:0]  idx_q, idx_d;
  logic [ADDR_W-1:0] a_base_q, a_base_d;
  logic [ADDR_W-1:0] b_base_q, b_base_d;
  logic [ADDR_W-1:0] r_base_q, r_base_d;
  logic [COLS-1:0]   a_reg_q, a_reg_d;
  logic [COLS-1:0]   carry_q, carry_d;
  logic [COLS-1:0]   carry_out_q, carry_out_d;
  logic [COLS-1:0]   b_eff;
`ifdef BITLINE_ADD_CTRL_SUB_EN
  logic              sub_q, sub_d;
`endif

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    a_base_d    = a_base_q;
    b_base_d    = b_base_q;
    r_base_d    = r_base_q;
    a_reg_d     = a_reg_q;
    carry_d     = carry_q;
    carry_out_d = carry_out_q;
    busy        = 1'b0;
    done        = 1'b0;
    mem_addr    = '0;
    mem_rd_en   = 1'b0;
    mem_wr_en   = 1'b0;
    mem_wdata   = '0;
    b_eff       = mem_rdata;
`ifdef BITLINE_ADD_CTRL_SUB_EN
    sub_d       = sub_q;
    if (sub_q) b_eff = ~mem_rdata;
`endif

    unique case (state_q)
      IDLE: begin
        if (start) begin
          a_base_d    = a_base;
          b_base_d    = b_base;
          r_base_d    = r_base;
          idx_d       = '0;
          carry_out_d = '0;
`ifdef BITLINE_ADD_CTRL_SUB_EN
          sub_d       = sub;
          carry_d     = {COLS{sub}};
`else
          carry_d     = '0;
`endif
          state_d     = RD_A;
        end
      end
      RD_A: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = a_base_q + ADDR_W'(idx_q);
        state_d   = RD_B;
      end
      RD_B: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        mem_addr  = b_base_q + ADDR_W'(idx_q);
        a_reg_d   = mem_rdata;
        state_d   = WR;
      end
      WR: begin
        busy      = 1'b1;
        mem_wr_en = 1'b1;
        mem_addr  = r_base_q + ADDR_W'(idx_q);
        mem_wdata = a_reg_q ^ b_eff ^ carry_q;
        // generate term a&b is what the bitline carry cell produces natively
        carry_d   = (a_reg_q & b_eff) | ((a_reg_q ^ b_eff) & carry_q);
        if (idx_q == LAST_IDX) begin
          carry_out_d = carry_d;
          state_d     = DONE;
        end else begin
          idx_d   = idx_q + IDX_W'(1);
          state_d = RD_A;
        end
      end
      DONE: begin
        done    = 1'b1;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      a_base_q    <= '0;
      b_base_q    <= '0;
      r_base_q    <= '0;
      a_reg_q     <= '0;
      carry_q     <= '0;
      carry_out_q <= '0;
`ifdef BITLINE_ADD_CTRL_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      a_base_q    <= a_base_d;
      b_base_q    <= b_base_d;
      r_base_q    <= r_base_d;
      a_reg_q     <= a_reg_d;
      carry_q     <= carry_d;
      carry_out_q <= carry_out_d;
`ifdef BITLINE_ADD_CTRL_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign carry_out = carry_out_q;

endmodule

// File: tb/tb_bitline_add_ctrl.sv
// Scoreboard bench for bitline_add_ctrl (WIDTH=4, COLS=4): word-level arithmetic model, monitor checks strobes and results.
module tb_bitline_add_ctrl;
  localparam int W  = 4;
  localparam int C  = 4;
  localparam int AW = 6;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [AW-1:0] a_base = '0, b_base = '0, r_base = '0;
  logic          busy, done, mem_rd_en, mem_wr_en;
  logic [C-1:0]  carry_out, mem_wdata;
  logic [C-1:0]  mem_rdata;
  logic [AW-1:0] mem_addr;
`ifdef BITLINE_ADD_CTRL_SUB_EN
  logic          sub = 1'b0;
`endif

  logic          tb_we = 1'b0;
  logic [AW-1:0] tb_addr = '0;
  logic [C-1:0]  tb_data = '0;
  logic [C-1:0]  mem [64];

  int errors = 0, checks = 0, cyc = 0, ops_done = 0;

  typedef struct {
    logic [AW-1:0] a, b, r;
    logic [15:0]   res;
    logic [3:0]    cout;
  } exp_t;
  exp_t q[$];

  bitline_add_ctrl #(.WIDTH(W), .COLS(C), .ADDR_W(AW)) dut (
    .clk(clk), .rst(rst), .start(start),
`ifdef BITLINE_ADD_CTRL_SUB_EN
    .sub(sub),
`endif
    .a_base(a_base), .b_base(b_base), .r_base(r_base),
    .busy(busy), .done(done), .carry_out(carry_out),
    .mem_addr(mem_addr), .mem_rd_en(mem_rd_en), .mem_rdata(mem_rdata),
    .mem_wr_en(mem_wr_en), .mem_wdata(mem_wdata)
  );

  always #5 clk = ~clk;

  // array model: registered read, garbage on non-read cycles to expose stale use
  always @(posedge clk) begin
    if (tb_we) mem[tb_addr] <= tb_data;
    else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
    mem_rdata <= mem_rd_en ? mem[mem_addr] : C'($urandom);
  end

  function automatic logic [3:0] row_of(input logic [15:0] w, input int i);
    logic [3:0] r;
    for (int c = 0; c < C; c++) r[c] = w[4*c + i];
    return r;
  endfunction

  task automatic chk(input bit ok, input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  task automatic load_words(input logic [AW-1:0] base, input logic [15:0] w);
    for (int i = 0; i < W; i++) begin
      @(negedge clk);
      tb_we   = 1'b1;
      tb_addr = AW'(base + i);
      tb_data = row_of(w, i);
    end
    @(negedge clk);
    tb_we = 1'b0;
  endtask

  // preload operands, push word-level expectation, present bases
  task automatic prep(input logic [AW-1:0] a, input logic [AW-1:0] b, input logic [AW-1:0] r,
                      input logic [15:0] wa, input logic [15:0] wb, input bit s);
    exp_t e;
    load_words(a, wa);
    load_words(b, wb);
    e.a = a; e.b = b; e.r = r; e.res = '0; e.cout = '0;
    for (int c = 0; c < C; c++) begin
      int x, y;
      x = int'(wa[4*c +: 4]);
      y = int'(wb[4*c +: 4]);
      if (s) begin
        e.res[4*c +: 4] = 4'((x - y + 16) % 16);
        e.cout[c]       = (x >= y);
      end else begin
        e.res[4*c +: 4] = 4'((x + y) % 16);
        e.cout[c]       = (x + y >= 16);
      end
    end
    q.push_back(e);
    a_base = a; b_base = b; r_base = r;
`ifdef BITLINE_ADD_CTRL_SUB_EN
    sub = s;
`endif
  endtask

  task automatic pulse_start();
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_ops(input int target);
    for (int k = 0; k < 200 && ops_done < target; k++) @(negedge clk);
    chk(ops_done >= target, "op_timeout", ops_done, target);
  endtask

  // monitor / scoreboard
  int   step = 0, first_cyc = 0;
  exp_t m;
  always begin
    @(posedge clk);
    #1;
    cyc++;
    if (rst) step = 0;
    else begin
      if (mem_rd_en || mem_wr_en) begin
        if (q.size() == 0) chk(1'b0, "unexpected_strobe", {mem_rd_en, mem_wr_en, mem_addr}, 0);
        else begin
          int bi, ph;
          logic [AW-1:0] ea;
          logic [3:0] ed;
          m  = q[0];
          bi = step / 3;
          ph = step % 3;
          ea = (ph == 0) ? AW'(m.a + bi) : (ph == 1) ? AW'(m.b + bi) : AW'(m.r + bi);
          ed = (ph == 2) ? row_of(m.res, bi) : 4'h0;
          if (step == 0) first_cyc = cyc;
          chk(step < 3*W && mem_rd_en == (ph != 2) && mem_wr_en == (ph == 2) && mem_addr == ea
              && busy && !done && (ph != 2 || mem_wdata == ed),
              "strobe", {mem_rd_en, mem_wr_en, mem_addr, mem_wdata}, {(ph != 2), (ph == 2), ea, ed});
          step++;
        end
      end
      if (done) begin
        if (q.size() == 0) chk(1'b0, "unexpected_done", 1, 0);
        else begin
          m = q.pop_front();
          chk(step == 3*W && cyc - first_cyc == 3*W && !busy, "done_timing", {step[15:0], 16'(cyc - first_cyc)}, {16'(3*W), 16'(3*W)});
          chk(carry_out == m.cout, "carry_out", carry_out, m.cout);
          for (int i = 0; i < W; i++)
            chk(mem[AW'(m.r + i)] == row_of(m.res, i), "result_row", mem[AW'(m.r + i)], row_of(m.res, i));
          step = 0;
          ops_done++;
        end
      end
    end
  end

  initial begin
    int n, base_ops, nwr;
    bit seen;
    // reset state
    repeat (2) @(negedge clk);
    chk(!busy && !done && !mem_rd_en && !mem_wr_en && carry_out == 0, "reset_state",
        {busy, done, mem_rd_en, mem_wr_en, carry_out}, 0);
    rst = 1'b0;

    // directed add, done latency from start edge
    prep(6'd0, 6'd8, 6'd16, 16'h90F3, 16'h6015, 1'b0);
    pulse_start();
    n = 1;
    while (!done && n < 40) begin @(negedge clk); n++; end
    chk(n == 3*W + 1, "done_cycle", n, 3*W + 1);
    wait_ops(1);

    // address wrap with in-place result
    prep(6'd62, 6'd2, 6'd62, 16'h5A3C, 16'hE7B1, 1'b0);
    pulse_start();
    wait_ops(2);

    // start held high: back-to-back, restart accepted in cycle after done
    base_ops = ops_done;
    prep(6'd20, 6'd30, 6'd40, 16'hFF01, 16'h01FF, 1'b0);
    q.push_back(q[q.size()-1]);
    @(negedge clk);
    start = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40 && !seen; k++) begin @(negedge clk); seen = done; end
    chk(seen, "held_first_done", seen, 1);
    @(negedge clk);
    chk(!busy && !done && !mem_rd_en, "idle_after_done", {busy, done, mem_rd_en}, 0);
    @(negedge clk);
    chk(busy && mem_rd_en && mem_addr == 6'd20, "restart", {busy, mem_rd_en, mem_addr}, {1'b1, 1'b1, 6'd20});
    start = 1'b0;
    repeat (4) @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    wait_ops(base_ops + 2);
    repeat (8) @(negedge clk);
    chk(ops_done == base_ops + 2 && !busy, "no_extra_op", ops_done, base_ops + 2);

    // reset in cycle 5 of an operation
    prep(6'd44, 6'd50, 6'd56, 16'h1234, 16'h4321, 1'b0);
    pulse_start();
    repeat (4) @(negedge clk);
    rst = 1'b1;
    q.delete();
    @(negedge clk);
    rst = 1'b0;
    chk(!busy && !done && !mem_rd_en && !mem_wr_en && carry_out == 0, "mid_reset_state",
        {busy, done, mem_rd_en, mem_wr_en, carry_out}, 0);
    nwr = 0;
    repeat (10) begin @(negedge clk); if (mem_wr_en) nwr++; end
    chk(nwr == 0, "no_write_after_reset", nwr, 0);
    base_ops = ops_done;
    prep(6'd44, 6'd50, 6'd56, 16'hA5C3, 16'h7E19, 1'b0);
    pulse_start();
    wait_ops(base_ops + 1);

`ifdef BITLINE_ADD_CTRL_SUB_EN
    prep(6'd4, 6'd10, 6'd24, 16'h0F27, 16'h0F53, 1'b1);
    pulse_start();
    wait_ops(ops_done + 1);
`endif

    // randomized operations with disjoint or in-place result regions
    for (int t = 0; t < 10; t++) begin
      logic [AW-1:0] a, b, r;
      int sel;
      bit s;
      a   = AW'($urandom);
      b   = AW'(a + 4 + $urandom_range(0, 8));
      sel = $urandom_range(0, 2);
      r   = (sel == 0) ? a : (sel == 1) ? b : AW'(b + 4 + $urandom_range(0, 8));
`ifdef BITLINE_ADD_CTRL_SUB_EN
      s = 1'($urandom);
`else
      s = 1'b0;
`endif
      base_ops = ops_done;
      prep(a, b, r, 16'($urandom), 16'($urandom), s);
      pulse_start();
      wait_ops(base_ops + 1);
    end

    repeat (3) @(negedge clk);
    chk(q.size() == 0, "scoreboard_empty", q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
